// File: rtl/serial_tx.sv
// serial_tx: start, 8 data bits LSB first, odd parity, stop framer fed by a byte FIFO.
// One line bit per clock, optional idle gap between frames.
module serial_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int IDLE_GAP   = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [7:0]                       in_byte,
    input  logic                             in_perr,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic                             out,
    output logic                             busy,
    output logic                             done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);
    localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, GAP
    } state_e;

    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;

    state_e        state_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [2:0]    bit_q;
    logic [GW-1:0] gap_q;
    logic          out_q;
    logic          busy_q;
    logic          done_q;

    logic          push;
    logic          pop;
    logic [8:0]    head;
    logic          head_par;

    always_comb begin
        head     = mem_q[rd_q];
        head_par = (~^head[7:0]) ^ head[8];
        in_ready = !reset && (level_q != FULL);
        push     = in_valid && in_ready;
        pop      = 1'b0;
        // Every state that may start a new frame pops the head directly.
        if (!reset && level_q != '0) begin
            unique case (state_q)
                IDLE:    pop = 1'b1;
                STOP:    pop = (IDLE_GAP == 0);
                GAP:     pop = (gap_q == GAP_LAST);
                default: pop = 1'b0;
            endcase
        end
        level_d = level_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= {in_perr, in_byte};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            par_q   <= 1'b0;
            bit_q   <= '0;
            gap_q   <= '0;
            out_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (pop) begin
                state_q <= START;
                shift_q <= head[7:0];
                par_q   <= head_par;
                out_q   <= 1'b0;
                busy_q  <= 1'b1;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        out_q  <= 1'b1;
                        busy_q <= 1'b0;
                    end
                    START: begin
                        state_q <= DATA;
                        out_q   <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        bit_q   <= '0;
                    end
                    DATA: begin
                        if (bit_q == 3'd7) begin
                            state_q <= PARITY;
                            out_q   <= par_q;
                        end else begin
                            out_q   <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                        bit_q <= bit_q + 3'd1;
                    end
                    PARITY: begin
                        state_q <= STOP;
                        out_q   <= 1'b1;
                        done_q  <= 1'b1;
                    end
                    STOP: begin
                        out_q <= 1'b1;
                        gap_q <= '0;
                        if (IDLE_GAP > 0) begin
                            state_q <= GAP;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    GAP: begin
                        out_q <= 1'b1;
                        if (gap_q == GAP_LAST) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            gap_q <= gap_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        out_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign out   = out_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign level = level_q;
endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: two instances (no gap, gap of 3) against a frame-queue model.
// Directed steps first, then a randomized stretch with occasional resets.
module tb_serial_tx;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_byte = 8'h00;
    logic       in_perr = 1'b0;
    logic       in_valid = 1'b0;

    logic       rdy0, out0, busy0, done0;
    logic [2:0] lvl0;
    logic       rdy3, out3, busy3, done3;
    logic [2:0] lvl3;

    serial_tx #(.FIFO_DEPTH(DEPTH), .IDLE_GAP(0)) u0 (
        .clk(clk), .reset(reset), .in_byte(in_byte), .in_perr(in_perr),
        .in_valid(in_valid), .in_ready(rdy0), .out(out0), .busy(busy0),
        .done(done0), .level(lvl0)
    );

    serial_tx #(.FIFO_DEPTH(DEPTH), .IDLE_GAP(3)) u3 (
        .clk(clk), .reset(reset), .in_byte(in_byte), .in_perr(in_perr),
        .in_valid(in_valid), .in_ready(rdy3), .out(out3), .busy(busy3),
        .done(done3), .level(lvl3)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference: FIFO of {perr,byte}; line queue of {done,bit} still to be shown.
    bit [8:0] fq0[$];
    bit [8:0] fq3[$];
    bit [1:0] lq0[$];
    bit [1:0] lq3[$];
    bit e_out0 = 1'b1, e_busy0 = 1'b0, e_done0 = 1'b0;
    bit e_out3 = 1'b1, e_busy3 = 1'b0, e_done3 = 1'b0;
    bit acc0, acc3;
    bit [8:0] ent0, ent3;
    bit [1:0] v0, v3;

    function automatic bit [1:0] fbit(input bit [8:0] ent, input int i);
        bit par;
        par = (($countones(ent[7:0]) % 2) == 0) ^ ent[8];
        if (i == 0) return 2'b00;
        if (i <= 8) return {1'b0, ent[i-1]};
        if (i == 9) return {1'b0, par};
        if (i == 10) return 2'b11;
        return 2'b01;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            fq0.delete(); lq0.delete();
            fq3.delete(); lq3.delete();
            e_out0 = 1'b1; e_busy0 = 1'b0; e_done0 = 1'b0;
            e_out3 = 1'b1; e_busy3 = 1'b0; e_done3 = 1'b0;
        end else begin
            acc0 = in_valid && (fq0.size() < DEPTH);
            acc3 = in_valid && (fq3.size() < DEPTH);
            if (lq0.size() == 0 && fq0.size() != 0) begin
                ent0 = fq0.pop_front();
                for (int i = 0; i < 11; i++) lq0.push_back(fbit(ent0, i));
            end
            if (lq3.size() == 0 && fq3.size() != 0) begin
                ent3 = fq3.pop_front();
                for (int i = 0; i < 14; i++) lq3.push_back(fbit(ent3, i));
            end
            if (acc0) fq0.push_back({in_perr, in_byte});
            if (acc3) fq3.push_back({in_perr, in_byte});
            if (lq0.size() != 0) begin
                v0 = lq0.pop_front();
                e_out0 = v0[0]; e_done0 = v0[1]; e_busy0 = 1'b1;
            end else begin
                e_out0 = 1'b1; e_done0 = 1'b0; e_busy0 = 1'b0;
            end
            if (lq3.size() != 0) begin
                v3 = lq3.pop_front();
                e_out3 = v3[0]; e_done3 = v3[1]; e_busy3 = 1'b1;
            end else begin
                e_out3 = 1'b1; e_done3 = 1'b0; e_busy3 = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("out0", int'(out0), int'(e_out0));
        chk("busy0", int'(busy0), int'(e_busy0));
        chk("done0", int'(done0), int'(e_done0));
        chk("level0", int'(lvl0), fq0.size());
        chk("ready0", int'(rdy0), int'(!reset && fq0.size() != DEPTH));
        chk("out3", int'(out3), int'(e_out3));
        chk("busy3", int'(busy3), int'(e_busy3));
        chk("done3", int'(done3), int'(e_done3));
        chk("level3", int'(lvl3), fq3.size());
        chk("ready3", int'(rdy3), int'(!reset && fq3.size() != DEPTH));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic push(input bit [7:0] b, input bit p);
        int n;
        in_byte = b;
        in_perr = p;
        in_valid = 1'b1;
        n = 0;
        while (!rdy0 && n < 100) begin
            cyc();
            n++;
        end
        chk("push_wait", int'(n < 100), 1);
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy0 || busy3 || lvl0 != 0 || lvl3 != 0) && n < 500) begin
            cyc();
            n++;
        end
        chk("drain_wait", int'(n < 500), 1);
    endtask

    int maxl = 0;
    always @(negedge clk) if (int'(lvl0) > maxl) maxl = int'(lvl0);

    bit exp_a5 [13] = '{1, 0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1, 1};
    int dcnt, t1, t2, g, n;

    initial begin
        for (int i = 0; i < 3; i++) cyc();
        chk("rst_ready", int'(rdy0), 0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", int'(rdy0), 1);

        push(8'hA5, 1'b0);
        for (int i = 0; i < 13; i++) begin
            if (i > 0) cyc();
            chk("a5_out", int'(out0), int'(exp_a5[i]));
            chk("a5_done", int'(done0), int'(i == 11));
        end
        chk("a5_busy_end", int'(busy0), 0);

        drain();
        push(8'h01, 1'b0);
        push(8'hFF, 1'b0);
        dcnt = 0; t1 = 0; t2 = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (done0) begin
                dcnt++;
                if (dcnt == 1) t1 = i; else t2 = i;
            end
        end
        chk("done_count", dcnt, 2);
        chk("done_spacing", t2 - t1, 11);

        drain();
        maxl = 0;
        for (int i = 0; i < 6; i++) push(8'($urandom), 1'b0);
        drain();
        chk("level_max", maxl, DEPTH);

        push(8'h01, 1'b1);
        for (int i = 0; i < 10; i++) cyc();
        chk("perr_parity", int'(out0), 1);
        drain();

        push(8'h3C, 1'b0);
        push(8'hC3, 1'b0);
        n = 0;
        while (!done3 && n < 40) begin
            cyc();
            n++;
        end
        chk("gap_done_wait", int'(n < 40), 1);
        g = 0;
        cyc();
        while (out3 && g < 10) begin
            chk("gap_busy", int'(busy3), 1);
            g++;
            cyc();
        end
        chk("gap_len", g, 3);
        drain();

        push(8'h00, 1'b0);
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        for (int i = 0; i < 4; i++) cyc();
        chk("bit4_out", int'(out0), 0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("mid_rst_out", int'(out0), 1);
        chk("mid_rst_level", int'(lvl0), 0);
        chk("mid_rst_busy", int'(busy0), 0);
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("post_rst_idle", int'(out0), 1);
        end

        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom % 3) != 0;
            in_byte = 8'($urandom);
            in_perr = ($urandom % 8) == 0;
            reset = ($urandom % 150) == 0;
            cyc();
        end
        in_valid = 1'b0;
        reset = 1'b0;
        cyc();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
